// File: rtl/alu_subtractor_serial.sv
// Digit-serial two's-complement subtractor D = A - B - Bin with Sign/Zero/Parity/Overflow/Bout flags.
// Optional feature macro: ALU_SUB_PARITY_EN builds the Parity flag; otherwise Parity is tied to 0.
module alu_subtractor_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Sign,
    output logic             Zero,
    output logic             Parity,
    output logic             Overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] d_acc;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_slice;
    logic [DIGIT-1:0] b_slice;
    logic [DIGIT-1:0] d_slice;
    logic             slice_borrow;
    logic [WIDTH-1:0] d_full;
    logic             last_slice;
    logic             accept;
    logic             finish;
    int               slice_base;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        slice_base = int'(cnt) * DIGIT;
        a_slice    = a_reg[slice_base +: DIGIT];
        b_slice    = b_reg[slice_base +: DIGIT];
        {slice_borrow, d_slice} = {1'b0, a_slice} - {1'b0, b_slice} - {{DIGIT{1'b0}}, borrow};
        d_full     = d_acc;
        d_full[slice_base +: DIGIT] = d_slice;
        last_slice = (cnt == LAST);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign finish    = (state == RUN) && last_slice;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers: operands are held whole so the flags can see the full MSBs at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            d_acc  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_reg  <= A;
            b_reg  <= B;
            d_acc  <= '0;
            borrow <= Bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            d_acc  <= d_full;
            borrow <= slice_borrow;
            cnt    <= last_slice ? '0 : cnt + CW'(1);
        end
    end

    // Visible results change only at the final digit edge and then hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D        <= '0;
            Bout     <= 1'b0;
            Sign     <= 1'b0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
        end else if (finish) begin
            D        <= d_full;
            Bout     <= slice_borrow;
            Sign     <= d_full[WIDTH-1];
            Zero     <= (d_full == '0);
            Overflow <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_full[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

`ifdef ALU_SUB_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (finish) begin
            parity_reg <= ~^d_full;
        end
    end

    assign Parity = parity_reg;
`else
    assign Parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_subtractor_serial.sv
// Self-checking bench for alu_subtractor_serial: directed cases, reset mid-run, then randomized ops
// scored against a plain-arithmetic model of A - B - Bin.
module tb_alu_subtractor_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Sign;
    logic             Zero;
    logic             Parity;
    logic             Overflow;

    int tests = 0;
    int fails = 0;

    alu_subtractor_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .Sign      (Sign),
        .Zero      (Zero),
        .Parity    (Parity),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned arithmetic on wide integers, flags straight from their definitions.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         output logic [WIDTH-1:0] d, output logic bout, output logic sign,
                         output logic zero, output logic par, output logic ovf);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        d    = WIDTH'(diff + (1 << WIDTH));
        bout = (int'(a) < int'(b) + int'(bin));
        sign = d[WIDTH-1];
        zero = (d == 0);
`ifdef ALU_SUB_PARITY_EN
        par  = ($countones(d) % 2 == 0);
`else
        par  = 1'b0;
`endif
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endtask

    // Called #1 after a rising edge; leaves the bench at the same phase.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                          input int hold, input bit scramble);
        logic [WIDTH-1:0] ed;
        logic eb, es, ez, ep, eo;
        logic [WIDTH-1:0] prev_d;
        int cyc;
        model(a, b, bin, ed, eb, es, ez, ep, eo);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("in_ready_idle", in_ready, 1);
        prev_d   = D;
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check("d_hold_run", D, prev_d);
            check("in_ready_run", in_ready, 0);
            if (scramble) begin
                A        = WIDTH'($urandom);
                B        = WIDTH'($urandom);
                Bin      = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, N);
        check("d", D, ed);
        check("bout", Bout, eb);
        check("sign", Sign, es);
        check("zero", Zero, ez);
        check("parity", Parity, ep);
        check("overflow", Overflow, eo);
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_d", D, ed);
            check("bp_flags", {Bout, Sign, Zero, Parity, Overflow}, {eb, es, ez, ep, eo});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_d_held", D, ed);
        check("idle_flags_held", {Bout, Sign, Zero, Parity, Overflow}, {eb, es, ez, ep, eo});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {D, Bout, Sign, Zero, Parity, Overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h8fff, 16'h8000, 1'b0, 0, 1'b0);
        run_op(16'h0002, 16'h0002, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'haaaa, 16'h5555, 1'b1, 0, 1'b0);
        run_op(16'h1234, 16'h0234, 1'b0, 5, 1'b1);
        run_op(16'h0000, 16'hffff, 1'b1, 0, 1'b0);
        run_op(16'hffff, 16'hffff, 1'b1, 0, 1'b0);
        run_op(16'h7fff, 16'hffff, 1'b0, 0, 1'b0);

        // Abort a run partway through with an asynchronous reset.
        A        = 16'h1234;
        B        = 16'h0fff;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_outputs", {D, Bout, Sign, Zero, Parity, Overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", in_ready, 1);
        run_op(16'h0010, 16'h0001, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_subtractor_serial.md
# alu_subtractor_serial

Multi-cycle, digit-serial two's-complement subtractor: D = A − B − Bin over WIDTH bits. It produces the same flag set as the datapath adder (Sign, Zero, Parity, Overflow) plus a borrow-out. It sits beside the ALU adder as its inverse-operation unit. Operands enter and results leave through valid/ready handshakes, so the block trades area for latency, at DIGIT bits per clock.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per clock; N = WIDTH/DIGIT digit cycles.
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset. Single clock domain.
- in_valid  input  1: operands valid.
- in_ready  output  1: block can accept operands; high only in IDLE.
- A  input  WIDTH: minuend.
- B  input  WIDTH: subtrahend.
- Bin  input  1: borrow-in.
- out_valid  output  1: result and flags valid; high only in DONE.
- out_ready  input  1: consumer takes the result.
- D  output  WIDTH: difference.
- Bout  output  1: borrow-out; 1 when unsigned A < B + Bin.
- Sign  output  1: D[WIDTH-1].
- Zero  output  1: D == 0.
- Parity  output  1: even parity of D; 1 when D has an even count of ones.
- Overflow  output  1: signed overflow, (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch A, B, Bin into operand registers, clear the digit counter, and go to RUN.
- RUN: each clock subtracts one DIGIT slice, LSB slice first.
  - Slice computation is {borrow, d} = a_slice − b_slice − borrow, with the borrow register seeded from Bin.
  - The slice result is written into D. The counter increments.
  - After slice N−1, go to DONE.
- DONE: out_valid=1.
  - D, Bout, and the flags are registered and stable.
  - Flags are computed from the full latched operands and final D.
  - On out_ready, go to IDLE.
- in_valid and A/B/Bin are ignored outside IDLE. Operands change after acceptance without affecting the result.
- Width rules: arithmetic is modulo 2^WIDTH. Bout is the final slice borrow. No sign extension.
- Reset (any state, including mid-RUN):
  - State=IDLE, in_ready=1, out_valid=0.
  - D=0, Bout=0, Sign=0, Zero=0, Parity=0, Overflow=0.
  - Counter and borrow cleared. Any in-flight operation is discarded.

## Timing
- Acceptance edge E0. Digit edges E1..EN. out_valid rises after EN.
  - With defaults, out_valid is first visible 4 cycles after the cycle in which in_valid&in_ready was sampled.
- out_valid stays high and all outputs are held indefinitely while out_ready=0.
- DONE→IDLE takes 1 cycle. in_ready is low in DONE, so there is no same-cycle result/operand overlap.
- Minimum initiation interval is N+2 cycles (6 with defaults).
- Outputs change only in RUN/DONE transitions. They are not cleared on return to IDLE; they hold the last result until the next EN.

## Configuration
- ALU_SUB_PARITY_EN defined:
  - The Parity flag is computed as above, registered at EN, and cleared by reset.
- ALU_SUB_PARITY_EN undefined:
  - No parity logic is built. Parity is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- A=8fff, B=8000, Bin=0 → D=0fff, Bout=0, Sign=0, Zero=0, Parity=1, Overflow=0. out_valid arrives 4 cycles after acceptance.
- A=0002, B=0002, Bin=0 → D=0000, Zero=1, Parity=1, Bout=0. Then A=0000, B=0001 → D=ffff, Bout=1, Sign=1, Parity=1, Overflow=0.
- A=8000, B=0001 → D=7fff, Overflow=1, Sign=0, Parity=0. Then A=aaaa, B=5555, Bin=1 → D=5554, Overflow=1, Bout=0, Parity=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, D, and flags stay constant and in_ready=0. Toggle A/B/in_valid during RUN → result unaffected.
- Assert rst_n=0 at RUN slice 2 → all outputs 0 and in_ready=1 immediately (asynchronously). A following operation A=0010, B=0001 → D=000f.
- Build without ALU_SUB_PARITY_EN and rerun scenario 1 → Parity=0, all other outputs unchanged.
